instruction_fetch: RTL

//  IF stage of the 5-stage MIPS pipeline. Producer side of the IF/ID interface that the ID stage consumes.

---
 rtl/mips_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instr_mem.sv | 29 ++
 rtl/instruction_fetch.sv | 95 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and fetch state encoding
// Purpose: constants and types used by the IF stage and its memory.
// Ports: none (package).
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - IF stage control/redirect/program-load/IF-ID bundle
// Purpose: groups the IF stage's non-clock signals.
// Ports (signals): i_enable, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_dir,
//   i_imem_we, i_imem_waddr, i_imem_wdata drive the stage; o_pc, o_instruction,
//   o_pc_plus_4, o_halted come back from it.
//   modport master: the controlling side (ID stage / debug / loader).
//   modport slave:  the IF stage itself.
interface instruction_fetch_if #(
  parameter int IMEM_AW = 8
);
  import mips_pkg::*;

  logic               i_enable;
  logic               i_stall;
  logic               i_pc_src;
  logic [31:0]        i_beq_jump_dir;
  logic               i_jump;
  logic [31:0]        i_jump_dir;
  logic               i_imem_we;
  logic [IMEM_AW-1:0] i_imem_waddr;
  logic [INSTR_W-1:0] i_imem_wdata;
  logic [31:0]        o_pc;
  logic [INSTR_W-1:0] o_instruction;
  logic [31:0]        o_pc_plus_4;
  logic               o_halted;

  modport master (
    output i_enable, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_dir,
           i_imem_we, i_imem_waddr, i_imem_wdata,
    input  o_pc, o_instruction, o_pc_plus_4, o_halted
  );

  modport slave (
    input  i_enable, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_dir,
           i_imem_we, i_imem_waddr, i_imem_wdata,
    output o_pc, o_instruction, o_pc_plus_4, o_halted
  );

endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory, one sync write port, one async read port
// Purpose: IMEM_DEPTH x 32 storage for the program; never cleared by reset.
// Ports: clk, we/waddr/wdata (write on rising edge), raddr -> rdata (combinational).
module instr_mem
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int IMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IMEM_AW-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [IMEM_AW-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write is not forwarded: the reader sees the old word until the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC, next-PC mux, IF/ID register, halt FSM
// Purpose: fetches from instr_mem, honours ID stall/branch/jump, flushes wrong-path
//   fetches with a NOP bubble and stops on a HALT opcode until reset.
// Ports: i_clk, i_reset (async, active high), bus (instruction_fetch_if.slave).
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_fetch_if.slave   bus
);

  fetch_state_e       state, state_n;
  logic [31:0]        pc, pc_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [31:0]        pp4_q, pp4_n;
  logic [INSTR_W-1:0] word;
  logic [31:0]        pc_plus_4;
  logic               advance;
  logic               redirect;
  logic               is_halt;

  // PC bits above the index are dropped, so fetch wraps modulo the memory depth.
  instr_mem #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_AW    (IMEM_AW)
  ) u_imem (
    .clk   (i_clk),
    .we    (bus.i_imem_we),
    .waddr (bus.i_imem_waddr),
    .wdata (bus.i_imem_wdata),
    .raddr (pc[IMEM_AW+1:2]),
    .rdata (word)
  );

  assign advance   = bus.i_enable & ~bus.i_stall;
  assign redirect  = bus.i_pc_src | bus.i_jump;
  assign pc_plus_4 = pc + 32'd4;
  assign is_halt   = (word[31:26] == HALT_OPCODE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      pp4_q   <= 32'h0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      pp4_q   <= pp4_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    pp4_n   = pp4_q;
    if (advance) begin
      pp4_n = pc_plus_4;
      case (state)
        RUN: begin
          if (bus.i_pc_src) begin
            pc_n = bus.i_beq_jump_dir;
          end else if (bus.i_jump) begin
            pc_n = bus.i_jump_dir;
          end else if (!is_halt) begin
            pc_n = pc_plus_4;
          end
          // A redirect squashes whatever was fetched this cycle, HALT included.
          instr_n = redirect ? NOP_INSTR : word;
          if (!redirect && is_halt) begin
            state_n = HALTED;
          end
        end
        HALTED: begin
          // PC frozen; keep feeding bubbles so the rest of the pipeline drains.
          instr_n = NOP_INSTR;
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign bus.o_pc          = pc;
  assign bus.o_instruction = instr_q;
  assign bus.o_pc_plus_4   = pp4_q;
  assign bus.o_halted      = (state == HALTED);

endmodule
